tc_pl_cap_buff_ctl: RTL and testbench

Capture-buffer fill stage of the PL capture chain. It sits directly downstream of the capture sequencer: it answers that sequencer's `buff_en` / `buff_cmpt` handshake by writing a fixed-length block of incoming samples into an on-chip buffer. It exposes a random-access read port so the following processing stage can consume the block once `buff_cmpt` is high.

---
 rtl/tc_pl_cap_pkg.sv | 14 +
 rtl/tc_pl_sdp_ram.sv | 26 ++
 rtl/tc_pl_cap_buff_ctl.sv | 111 +++++++++++
 tb/tb_tc_pl_cap_buff_ctl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pl_cap_pkg.sv
// Shared definitions for the PL capture chain: fill-stage state encoding and default block sizing.
package tc_pl_cap_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } cap_state_t;

  localparam int CAP_DATA_W = 16;
  localparam int CAP_DEPTH  = 1024;

endpackage

// File: rtl/tc_pl_sdp_ram.sv
// Simple dual-port RAM: one write port, registered read port (1-cycle latency, read-first on collision).
// No flow control; both ports are usable every cycle.
module tc_pl_sdp_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Read and write share one block so a same-address read returns the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/tc_pl_cap_buff_ctl.sv
// Capture-buffer fill stage: answers buff_en/buff_cmpt by writing one DEPTH-sample block; read port has 1-cycle latency.
// No backpressure, samples outside S_FILL are dropped; CAP_BUFF_TIMEOUT_EN adds an idle-cycle timeout.
module tc_pl_cap_buff_ctl
  import tc_pl_cap_pkg::*;
#(
  parameter int DATA_W      = CAP_DATA_W,
  parameter int DEPTH       = CAP_DEPTH,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              buff_en,
  output logic              buff_cmpt,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              smp_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   wr_cnt,
  output logic              buff_timeout
);

  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  cap_state_t state;
  logic       wr_en;

`ifdef CAP_BUFF_TIMEOUT_EN
  localparam int              IDLE_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout_q;

  assign buff_timeout = timeout_q;
`else
  assign buff_timeout = 1'b0;
`endif

  // Write strobe follows the same priority as the FSM so an abort or reset edge never writes.
  assign wr_en = rst && buff_en && (state == S_FILL) && smp_valid;

  tc_pl_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_cnt[ADDR_W-1:0]),
    .wr_data (smp_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      buff_cmpt <= 1'b0;
      wr_cnt    <= '0;
`ifdef CAP_BUFF_TIMEOUT_EN
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else if (!buff_en) begin
      // wr_cnt is left alone so an aborted block still reports its partial count.
      state     <= S_IDLE;
      buff_cmpt <= 1'b0;
`ifdef CAP_BUFF_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: state <= S_ARM;
        S_ARM: begin
          wr_cnt   <= '0;
`ifdef CAP_BUFF_TIMEOUT_EN
          idle_cnt <= '0;
`endif
          state    <= S_FILL;
        end
        S_FILL: begin
          if (smp_valid) begin
            wr_cnt <= wr_cnt + CNT_ONE;
`ifdef CAP_BUFF_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (wr_cnt == CNT_LAST) begin
              state     <= S_DONE;
              buff_cmpt <= 1'b1;
            end
          end
`ifdef CAP_BUFF_TIMEOUT_EN
          else if (idle_cnt == IDLE_LAST) begin
            state     <= S_DONE;
            buff_cmpt <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + IDLE_ONE;
          end
`endif
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tc_pl_cap_buff_ctl.sv
// Directed bench for the capture-buffer fill stage at DEPTH=8, TIMEOUT_CYC=16.
module tb_tc_pl_cap_buff_ctl;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int TO_CYC = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              buff_en;
  logic              buff_cmpt;
  logic [DATA_W-1:0] smp_data;
  logic              smp_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   wr_cnt;
  logic              buff_timeout;

  int total = 0;
  int bad   = 0;

  tc_pl_cap_buff_ctl #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .buff_en      (buff_en),
    .buff_cmpt    (buff_cmpt),
    .smp_data     (smp_data),
    .smp_valid    (smp_valid),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .wr_cnt       (wr_cnt),
    .buff_timeout (buff_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; buff_en = 1'b0; smp_valid = 1'b0; smp_data = '0; rd_addr = '0;
    repeat (3) tick();
    total++; if (buff_cmpt !== 1'b0) begin bad++; $display("FAIL reset_cmpt: got %b want 0", buff_cmpt); end
    total++; if (buff_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", buff_timeout); end
    total++; if (wr_cnt !== 4'd0) begin bad++; $display("FAIL reset_wr_cnt: got %0d want 0", wr_cnt); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_full_block();
    buff_en = 1'b1;
    tick();  // E
    tick();  // E+1, now filling
    smp_valid = 1'b1; smp_data = 16'h0000;
    for (int i = 0; i < DEPTH; i++) begin
      tick();  // edge E+2+i
      smp_data = 16'(i + 1);
      if (i == DEPTH - 2) begin
        total++; if (buff_cmpt !== 1'b0) begin bad++; $display("FAIL full_cmpt_early: got %b want 0 at E+8", buff_cmpt); end
      end
    end
    smp_valid = 1'b0;
    total++; if (buff_cmpt !== 1'b1) begin bad++; $display("FAIL full_cmpt_rise: got %b want 1 at E+9", buff_cmpt); end
    total++; if (wr_cnt !== 4'd8) begin bad++; $display("FAIL full_wr_cnt: got %0d want 8", wr_cnt); end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = 3'(a);
      tick();
      total++; if (rd_data !== 16'(a)) begin bad++; $display("FAIL full_read[%0d]: got %h want %h", a, rd_data, 16'(a)); end
    end
    buff_en = 1'b0;
    tick();
    total++; if (buff_cmpt !== 1'b0) begin bad++; $display("FAIL full_cmpt_fall: got %b want 0", buff_cmpt); end
    total++; if (wr_cnt !== 4'd8) begin bad++; $display("FAIL full_wr_cnt_hold: got %0d want 8", wr_cnt); end
  endtask

  task automatic test_gapped();
    // Valid is high through the idle and arm cycles; that sample must be dropped.
    buff_en = 1'b1; smp_valid = 1'b1; smp_data = 16'hAAAA;
    tick();
    tick();
    total++; if (wr_cnt !== 4'd0) begin bad++; $display("FAIL gap_arm_wr_cnt: got %0d want 0", wr_cnt); end
    for (int i = 0; i < DEPTH; i++) begin
      smp_valid = 1'b1; smp_data = 16'(16'h10 + i);
      tick();
      smp_valid = 1'b0; smp_data = 16'hBBBB;
      tick();
      if (i == DEPTH - 2) begin
        total++; if (buff_cmpt !== 1'b0 || wr_cnt !== 4'd7) begin bad++; $display("FAIL gap_before_last: cmpt=%b cnt=%0d want 0/7", buff_cmpt, wr_cnt); end
      end
    end
    total++; if (buff_cmpt !== 1'b1) begin bad++; $display("FAIL gap_cmpt: got %b want 1", buff_cmpt); end
    smp_valid = 1'b1; smp_data = 16'hFFFF;
    tick();
    smp_valid = 1'b0;
    total++; if (wr_cnt !== 4'd8) begin bad++; $display("FAIL gap_ninth_cnt: got %0d want 8", wr_cnt); end
    rd_addr = 3'd0;
    tick();
    total++; if (rd_data !== 16'h0010) begin bad++; $display("FAIL gap_read0: got %h want 0010", rd_data); end
    rd_addr = 3'd7;
    tick();
    total++; if (rd_data !== 16'h0017) begin bad++; $display("FAIL gap_read7: got %h want 0017", rd_data); end
    buff_en = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    buff_en = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      smp_valid = 1'b1; smp_data = 16'(16'h20 + i);
      tick();
    end
    smp_valid = 1'b0; buff_en = 1'b0;
    tick();
    total++; if (buff_cmpt !== 1'b0) begin bad++; $display("FAIL abort_cmpt: got %b want 0", buff_cmpt); end
    total++; if (wr_cnt !== 4'd3) begin bad++; $display("FAIL abort_wr_cnt: got %0d want 3", wr_cnt); end
    rd_addr = 3'd2;
    tick();
    total++; if (rd_data !== 16'h0022) begin bad++; $display("FAIL abort_read2: got %h want 0022", rd_data); end
    rd_addr = 3'd3;
    tick();
    total++; if (rd_data !== 16'h0013) begin bad++; $display("FAIL abort_read3: got %h want 0013", rd_data); end
    // Re-arm: first write lands at address 0 while reading it, so the old word comes back.
    buff_en = 1'b1;
    tick();
    tick();
    total++; if (wr_cnt !== 4'd0) begin bad++; $display("FAIL rearm_wr_cnt: got %0d want 0", wr_cnt); end
    rd_addr = 3'd0; smp_valid = 1'b1; smp_data = 16'h0030;
    tick();
    total++; if (rd_data !== 16'h0020) begin bad++; $display("FAIL rearm_collision: got %h want 0020", rd_data); end
    total++; if (wr_cnt !== 4'd1) begin bad++; $display("FAIL rearm_cnt1: got %0d want 1", wr_cnt); end
    for (int i = 1; i < DEPTH; i++) begin
      smp_data = 16'(16'h30 + i);
      tick();
      if (i == 1) begin
        total++; if (rd_data !== 16'h0030) begin bad++; $display("FAIL rearm_read0: got %h want 0030", rd_data); end
      end
    end
    smp_valid = 1'b0;
    total++; if (buff_cmpt !== 1'b1) begin bad++; $display("FAIL rearm_cmpt: got %b want 1", buff_cmpt); end
  endtask

  task automatic test_handshake_hold();
    smp_valid = 1'b1; smp_data = 16'hDEAD;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if (buff_cmpt !== 1'b1) begin bad++; $display("FAIL hold_cmpt[%0d]: got %b want 1", i, buff_cmpt); end
    end
    smp_valid = 1'b0;
    total++; if (wr_cnt !== 4'd8) begin bad++; $display("FAIL hold_wr_cnt: got %0d want 8", wr_cnt); end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = 3'(a);
      tick();
      total++; if (rd_data !== 16'(16'h30 + a)) begin bad++; $display("FAIL hold_read[%0d]: got %h want %h", a, rd_data, 16'(16'h30 + a)); end
    end
    buff_en = 1'b0;
    tick();
    total++; if (buff_cmpt !== 1'b0) begin bad++; $display("FAIL hold_cmpt_fall: got %b want 0", buff_cmpt); end
  endtask

  task automatic test_reset_mid_fill();
    buff_en = 1'b1;
    tick();
    tick();
    smp_valid = 1'b1; smp_data = 16'h0050;
    tick();
    tick();
    rst = 1'b0; smp_data = 16'h0040;
    tick();
    total++; if (buff_cmpt !== 1'b0 || buff_timeout !== 1'b0) begin bad++; $display("FAIL rstmid_flags: cmpt=%b to=%b want 0/0", buff_cmpt, buff_timeout); end
    total++; if (wr_cnt !== 4'd0) begin bad++; $display("FAIL rstmid_wr_cnt: got %0d want 0", wr_cnt); end
    rst = 1'b1;
    tick();  // idle -> arm
    tick();  // arm, sample dropped
    total++; if (wr_cnt !== 4'd0) begin bad++; $display("FAIL rstmid_arm_drop: got %0d want 0", wr_cnt); end
    tick();
    total++; if (wr_cnt !== 4'd1) begin bad++; $display("FAIL rstmid_first_write: got %0d want 1", wr_cnt); end
    smp_valid = 1'b0; buff_en = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    buff_en = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      smp_valid = 1'b1; smp_data = 16'(16'h60 + i);
      tick();
    end
    smp_valid = 1'b0;
`ifdef CAP_BUFF_TIMEOUT_EN
    repeat (TO_CYC - 1) tick();
    total++; if (buff_cmpt !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0 after 15 idle", buff_cmpt); end
    tick();
    total++; if (buff_cmpt !== 1'b1 || buff_timeout !== 1'b1) begin bad++; $display("FAIL to_fire: cmpt=%b to=%b want 1/1", buff_cmpt, buff_timeout); end
`else
    repeat (40) tick();
    total++; if (buff_cmpt !== 1'b0 || buff_timeout !== 1'b0) begin bad++; $display("FAIL to_absent: cmpt=%b to=%b want 0/0", buff_cmpt, buff_timeout); end
`endif
    total++; if (wr_cnt !== 4'd5) begin bad++; $display("FAIL to_wr_cnt: got %0d want 5", wr_cnt); end
    buff_en = 1'b0;
    tick();
    total++; if (buff_cmpt !== 1'b0 || buff_timeout !== 1'b0) begin bad++; $display("FAIL to_clear: cmpt=%b to=%b want 0/0", buff_cmpt, buff_timeout); end
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_gapped();
    test_abort();
    test_handshake_hold();
    test_reset_mid_fill();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
